// File: rtl/digit_match_pkg.sv
// Shared definitions for the digit template-matching controller:
// geometry, widths, FSM state codes, thresholds and a row-slicing helper.
// Optional feature macro used by the top: DIGIT_MATCH_AMBIG_EN.
package digit_match_pkg;

    localparam int ROWS       = 16;
    localparam int COLS       = 16;
    localparam int NUM_DIGITS = 10;
    localparam int ROW_W      = 4;
    localparam int SCORE_W    = 9;
    localparam int DIGIT_W    = 4;
    localparam int AGREE_W    = 5;

    localparam logic [SCORE_W-1:0] MIN_SCORE = 9'd200;
    localparam logic [SCORE_W-1:0] MARGIN    = 9'd8;

    localparam logic [ROW_W-1:0]   LAST_ROW  = 4'(ROWS - 1);
    localparam logic [DIGIT_W-1:0] DEC_LAST  = 4'(NUM_DIGITS);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SCAN   = 3'd1;
    localparam state_t ST_FLUSH  = 3'd2;
    localparam state_t ST_DECIDE = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    // Extract digit d's row from the flat ROM bus (digit d at [16d+15:16d]).
    function automatic logic [COLS-1:0] digit_row(
        input logic [NUM_DIGITS*COLS-1:0] rows,
        input int unsigned                d
    );
        digit_row = rows[d*COLS +: COLS];
    endfunction

endpackage

// File: rtl/digit_match_row_agree_count.sv
// Counts pixel positions where a template row and an image row agree
// (popcount of the XNOR), 0..16.
module row_agree_count
    import digit_match_pkg::*;
(
    input  logic [COLS-1:0]    tmpl_row,
    input  logic [COLS-1:0]    img_row,
    output logic [AGREE_W-1:0] agree
);

    logic [COLS-1:0] same_s;

    // Sum the agreeing pixel positions of the row pair
    always_comb begin
        same_s = ~(tmpl_row ^ img_row);
        agree  = 5'd0;
        for (int i = 0; i < COLS; i++) begin
            agree = agree + {4'd0, same_s[i]};
        end
    end

endmodule

// File: rtl/digit_match_ctrl.sv
// Template-matching sequencer: scans 16 rows of the image buffer and all ten
// digit ROMs with a shared row address, accumulates per-digit agreement
// scores, then runs a one-digit-per-cycle argmax and publishes the result.
// Optional: define DIGIT_MATCH_AMBIG_EN to add second-best tracking and the
// result_ambig output.
module digit_match_ctrl
    import digit_match_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic [ROW_W-1:0]           rom_row_addr,
    input  logic [NUM_DIGITS*COLS-1:0] rom_rows,
    output logic                       img_rd_en,
    output logic [ROW_W-1:0]           img_row_addr,
    input  logic [COLS-1:0]            img_row,
    output logic [DIGIT_W-1:0]         result_digit,
    output logic [SCORE_W-1:0]         result_score,
    output logic                       result_reject,
`ifdef DIGIT_MATCH_AMBIG_EN
    output logic                       result_ambig,
`endif
    output logic                       done
);

    state_t                    state_r;
    logic [ROW_W-1:0]          addr_r;
    logic                      busy_r;
    logic                      rd_en_r;
    logic                      done_r;
    logic [DIGIT_W-1:0]        dcnt_r;
    logic [NUM_DIGITS*COLS-1:0] tmpl_r;
    logic                      tmpl_vld_r;
    logic [SCORE_W-1:0]        score_r [NUM_DIGITS];
    logic [SCORE_W-1:0]        best_r;
    logic [DIGIT_W-1:0]        idx_r;
    logic [DIGIT_W-1:0]        res_digit_r;
    logic [SCORE_W-1:0]        res_score_r;
    logic                      res_reject_r;
    logic [SCORE_W-1:0]        cand_s;
    logic                      accept_s;
    logic [AGREE_W-1:0]        agree_s [NUM_DIGITS];
`ifdef DIGIT_MATCH_AMBIG_EN
    logic [SCORE_W-1:0]        second_r;
    logic                      res_ambig_r;
`endif

    assign accept_s = (state_r == ST_IDLE) && start;

    // One popcount per digit on the registered template row vs. the image row
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_cnt
        row_agree_count u_cnt (
            .tmpl_row (digit_row(tmpl_r, g)),
            .img_row  (img_row),
            .agree    (agree_s[g])
        );
    end

    // FSM: row scan, pipeline flush, argmax steps, one-cycle done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= 4'd0;
            busy_r  <= 1'b0;
            rd_en_r <= 1'b0;
            done_r  <= 1'b0;
            dcnt_r  <= 4'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_SCAN;
                        busy_r  <= 1'b1;
                        rd_en_r <= 1'b1;
                        addr_r  <= 4'd0;
                        dcnt_r  <= 4'd0;
                    end
                end
                ST_SCAN: begin
                    if (addr_r == LAST_ROW) begin
                        state_r <= ST_FLUSH;
                        rd_en_r <= 1'b0;
                        addr_r  <= 4'd0;
                    end else begin
                        addr_r <= addr_r + 4'd1;
                    end
                end
                ST_FLUSH: begin
                    state_r <= ST_DECIDE;
                    dcnt_r  <= 4'd0;
                end
                ST_DECIDE: begin
                    if (dcnt_r == DEC_LAST) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        dcnt_r  <= 4'd0;
                    end else begin
                        dcnt_r <= dcnt_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    rd_en_r <= 1'b0;
                    addr_r  <= 4'd0;
                    dcnt_r  <= 4'd0;
                end
            endcase
        end
    end

    // Two-stage datapath: latch ROM rows beside the image read, then accumulate
    always_ff @(posedge clk) begin
        if (rst) begin
            tmpl_r     <= {(NUM_DIGITS*COLS){1'b0}};
            tmpl_vld_r <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                score_r[d] <= 9'd0;
            end
        end else begin
            tmpl_vld_r <= (state_r == ST_SCAN);
            if (state_r == ST_SCAN) begin
                tmpl_r <= rom_rows;
            end
            if (accept_s) begin
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    score_r[d] <= 9'd0;
                end
            end else if (tmpl_vld_r) begin
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    score_r[d] <= score_r[d] + {4'd0, agree_s[d]};
                end
            end
        end
    end

    // Score under inspection during the current argmax step
    always_comb begin
        cand_s = 9'd0;
        if (dcnt_r < DEC_LAST) begin
            cand_s = score_r[dcnt_r];
        end else begin
            cand_s = 9'd0;
        end
    end

    // Sequential argmax (strictly greater wins, so ties keep the lower digit)
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            best_r       <= 9'd0;
            idx_r        <= 4'd0;
            res_digit_r  <= 4'd0;
            res_score_r  <= 9'd0;
            res_reject_r <= 1'b0;
`ifdef DIGIT_MATCH_AMBIG_EN
            second_r     <= 9'd0;
            res_ambig_r  <= 1'b0;
`endif
        end else if (state_r == ST_DECIDE) begin
            if (dcnt_r == 4'd0) begin
                best_r   <= cand_s;
                idx_r    <= 4'd0;
`ifdef DIGIT_MATCH_AMBIG_EN
                second_r <= 9'd0;
`endif
            end else if (dcnt_r < DEC_LAST) begin
                if (cand_s > best_r) begin
                    best_r   <= cand_s;
                    idx_r    <= dcnt_r;
`ifdef DIGIT_MATCH_AMBIG_EN
                    second_r <= best_r;
`endif
                end
`ifdef DIGIT_MATCH_AMBIG_EN
                else if (cand_s > second_r) begin
                    second_r <= cand_s;
                end
`endif
            end else begin
                res_digit_r  <= idx_r;
                res_score_r  <= best_r;
                res_reject_r <= (best_r < MIN_SCORE);
`ifdef DIGIT_MATCH_AMBIG_EN
                res_ambig_r  <= ((best_r - second_r) < MARGIN);
`endif
            end
        end
    end

    assign busy          = busy_r;
    assign rom_row_addr  = addr_r;
    assign img_row_addr  = addr_r;
    assign img_rd_en     = rd_en_r;
    assign done          = done_r;
    assign result_digit  = res_digit_r;
    assign result_score  = res_score_r;
    assign result_reject = res_reject_r;
`ifdef DIGIT_MATCH_AMBIG_EN
    assign result_ambig  = res_ambig_r;
`endif

endmodule

// File: tb/tb_digit_match_ctrl.sv
// Self-checking bench for digit_match_ctrl: behavioural ROM and image-buffer
// stubs, a pass-timeline/score model, a per-cycle compare process, and
// directed plus randomized passes. Honours DIGIT_MATCH_AMBIG_EN.
module tb_digit_match_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         busy;
    logic [3:0]   rom_row_addr;
    logic [159:0] rom_rows;
    logic         img_rd_en;
    logic [3:0]   img_row_addr;
    logic [15:0]  img_row = 16'd0;
    logic [3:0]   result_digit;
    logic [8:0]   result_score;
    logic         result_reject;
    logic         result_ambig;
    logic         done;

    logic [15:0]  tmpl [10][16];
    logic [15:0]  img  [16];

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    digit_match_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .rom_row_addr  (rom_row_addr),
        .rom_rows      (rom_rows),
        .img_rd_en     (img_rd_en),
        .img_row_addr  (img_row_addr),
        .img_row       (img_row),
        .result_digit  (result_digit),
        .result_score  (result_score),
        .result_reject (result_reject),
`ifdef DIGIT_MATCH_AMBIG_EN
        .result_ambig  (result_ambig),
`endif
        .done          (done)
    );

`ifndef DIGIT_MATCH_AMBIG_EN
    assign result_ambig = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational template ROM stubs
    for (genvar g = 0; g < 10; g++) begin : g_rom
        assign rom_rows[16*g +: 16] = tmpl[g][rom_row_addr];
    end

    // Synchronous image buffer stub
    always @(posedge clk) begin
        if (img_rd_en) img_row <= img[img_row_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int score_of(input int d);
        int s = 0;
        for (int r = 0; r < 16; r++) s += $countones(~(tmpl[d][r] ^ img[r]));
        return s;
    endfunction

    function automatic int model_digit();
        int best = -1;
        int bi = 0;
        for (int d = 0; d < 10; d++) begin
            if (score_of(d) > best) begin best = score_of(d); bi = d; end
        end
        return bi;
    endfunction

    function automatic int model_ambig();
        int w = model_digit();
        int second = 0;
        for (int d = 0; d < 10; d++) begin
            if (d != w && score_of(d) > second) second = score_of(d);
        end
        return ((score_of(w) - second) < 8) ? 1 : 0;
    endfunction

    bit m_init = 1'b0;
    bit m_active = 1'b0;
    bit m_has = 1'b0;
    int m_n = 0;
    int m_dig = 0;
    int m_sc = 0;
    int m_amb = 0;
    bit res_v;

    // Pass timeline: edges counted from the accepting edge
    always @(posedge clk) begin
        if (rst) begin
            m_init   <= 1'b1;
            m_active <= 1'b0;
            m_has    <= 1'b0;
            m_n      <= 0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_has    <= 1'b0;
                m_n      <= 0;
                m_dig    <= model_digit();
                m_sc     <= score_of(model_digit());
                m_amb    <= model_ambig();
            end
        end else if (m_n == 28) begin
            m_active <= 1'b0;
            m_has    <= 1'b1;
        end else begin
            m_n <= m_n + 1;
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        if (m_init) begin
            res_v = (m_active && m_n == 28) || (!m_active && m_has);
            chk("busy", busy, m_active ? 1 : 0);
            chk("img_rd_en", img_rd_en, (m_active && m_n <= 15) ? 1 : 0);
            chk("rom_row_addr", rom_row_addr, (m_active && m_n <= 15) ? m_n : 0);
            chk("img_row_addr", img_row_addr, (m_active && m_n <= 15) ? m_n : 0);
            chk("done", done, (m_active && m_n == 28) ? 1 : 0);
            chk("result_digit", result_digit, res_v ? m_dig : 0);
            chk("result_score", result_score, res_v ? m_sc : 0);
            chk("result_reject", result_reject, (res_v && m_sc < 200) ? 1 : 0);
`ifdef DIGIT_MATCH_AMBIG_EN
            chk("result_ambig", result_ambig, res_v ? m_amb : 0);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_defaults();
        for (int d = 0; d < 10; d++)
            for (int r = 0; r < 16; r++)
                tmpl[d][r] = ~(16'h0001 << ((d + r) % 16));
    endtask

    task automatic clear_img();
        for (int r = 0; r < 16; r++) img[r] = 16'h0000;
    endtask

    task automatic copy_img(input int d);
        for (int r = 0; r < 16; r++) img[r] = tmpl[d][r];
    endtask

    // Template d gets exactly n set pixels, from the first or last positions
    task automatic set_ones(input int d, input int n, input bit from_end);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                tmpl[d][r][15-c] = from_end ? ((r*16 + c) >= (256 - n)) : ((r*16 + c) < n);
    endtask

    // Start one pass from a falling edge and wait (bounded) for done
    task automatic run_pass(input bit rnd_start);
        int c0;
        int lat;
        bit seen;
        start = 1'b1;
        c0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rnd_start && cyc < c0 + 25) start = ($urandom_range(0, 3) == 0);
            else start = 1'b0;
            if (done) begin seen = 1'b1; lat = cyc - c0; end
        end
        start = 1'b0;
        chk("accept_to_done_latency", lat, 28);
    endtask

    int nd;
    int c0;
    int dt [3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        set_defaults();
        clear_img();
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_score", result_score, 0);
        rst = 1'b0;
        @(negedge clk);

        // Exact match on digit 7
        copy_img(7);
        run_pass(1'b0);
        chk("exact_digit", result_digit, 7);
        chk("exact_score", result_score, 256);
        chk("exact_reject", result_reject, 0);
        repeat (2) @(negedge clk);

        // Tie between identical templates 3 and 5
        for (int r = 0; r < 16; r++) tmpl[5][r] = tmpl[3][r];
        copy_img(3);
        run_pass(1'b0);
        chk("tie_digit", result_digit, 3);
        chk("tie_score", result_score, 256);
        set_defaults();
        repeat (2) @(negedge clk);

        // Weak match: best 150 on digit 2
        set_ones(2, 106, 1'b0);
        clear_img();
        run_pass(1'b0);
        chk("weak_digit", result_digit, 2);
        chk("weak_score", result_score, 150);
        chk("weak_reject", result_reject, 1);
        set_defaults();
        repeat (2) @(negedge clk);

`ifdef DIGIT_MATCH_AMBIG_EN
        clear_img();
        set_ones(1, 16, 1'b0);
        set_ones(4, 20, 1'b1);
        run_pass(1'b0);
        chk("ambig_digit", result_digit, 1);
        chk("ambig_score", result_score, 240);
        chk("ambig_close", result_ambig, 1);
        repeat (2) @(negedge clk);
        set_ones(4, 36, 1'b1);
        run_pass(1'b0);
        chk("ambig_clear", result_ambig, 0);
        set_defaults();
        repeat (2) @(negedge clk);
`endif

        // Start pulsed at E5 and E20 during a pass is ignored
        copy_img(4);
        start = 1'b1;
        c0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = (cyc == c0 + 4) || (cyc == c0 + 19);
            if (done) nd++;
        end
        start = 1'b0;
        chk("ignored_start_done_count", nd, 1);

        // Start held high re-arms at E30 and E60
        copy_img(9);
        start = 1'b1;
        c0 = cyc + 1;
        nd = 0;
        for (int i = 0; i < 120 && nd < 3; i++) begin
            @(negedge clk);
            if (done) begin
                dt[nd] = cyc - c0;
                nd++;
                if (nd == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("held_done_count", nd, 3);
        chk("held_done1", dt[0], 28);
        chk("held_done2", dt[1], 58);
        chk("held_done3", dt[2], 88);
        repeat (3) @(negedge clk);

        // Reset at E10 aborts the pass
        copy_img(6);
        start = 1'b1;
        c0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && cyc < c0 + 9; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_en", img_rd_en, 0);
        chk("midrst_addr", rom_row_addr, 0);
        chk("midrst_done", done, 0);
        rst = 1'b0;
        run_pass(1'b0);
        chk("after_rst_digit", result_digit, 6);
        chk("after_rst_score", result_score, 256);
        repeat (2) @(negedge clk);

        // Randomized images near a random template, with stray start pulses
        for (int p = 0; p < 10; p++) begin
            int tgt;
            int nflip;
            int b;
            tgt = $urandom_range(0, 9);
            nflip = $urandom_range(0, 130);
            copy_img(tgt);
            for (int k = 0; k < nflip; k++) begin
                b = $urandom_range(0, 255);
                img[b / 16][b % 16] = ~img[b / 16][b % 16];
            end
            run_pass(1'b1);
            repeat (2) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
